clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
Parametrised, run-time programmable multi-channel clock divider. It supersedes the fixed two-tap power-of-two divider. Each channel has its own divisor register and produces two outputs from the system clock:
- a one-cycle tick-enable, for use as a clock enable in downstream logic;
- a 50%-duty divided square wave, for LED/display drive.
It sits at the top level beside the display multiplexer and the seconds counter.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..16).
- CNT_W, 26, width of each divisor and counter.
- CH_W, 1, width of the channel select; must equal max(1, clog2(NUM_CH)).
- RESET_DIV, 50000000, divisor loaded into every channel at reset (1 Hz square out at 100 MHz).

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, synchronous, active-low reset; asserted when 0 and sampled on the Clk rising edge.
- En, input, NUM_CH, per-channel run enable.
- Sync, input, 1, phase restart of all channels.
- Wr_En, input, 1, divisor write strobe.
- Wr_Ch, input, CH_W, channel selected for the write.
- Wr_Div, input, CNT_W, divisor value N to write.
- Tick, output, NUM_CH, registered one-cycle pulse, once every N enabled cycles.
- Clk_Out, output, NUM_CH, registered square wave; toggles on each tick, so its period is 2N cycles.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - all counters = 0, all divisors = RESET_DIV;
  - Tick = 0 and Clk_Out = 0 on every channel;
  - reset overrides every other input in that cycle;
  - reset asserted mid-count discards the count.
- Per-channel counter cnt runs 0..N-1 while En[i]=1.
- Terminal condition is cnt >= N-1. On a terminal cycle:
  - cnt <= 0;
  - Tick[i] <= 1 (high for exactly the next cycle);
  - Clk_Out[i] <= ~Clk_Out[i].
- On a non-terminal cycle: cnt <= cnt+1 and Tick[i] <= 0.
- Latency: the first Tick arrives N cycles after En rises, counting from cnt=0.
- N=1: Tick is constantly high and Clk_Out toggles every cycle (Clk/2).
- N=0: the channel is halted. cnt holds at 0, Tick=0, Clk_Out holds its value.
- En[i]=0: cnt and Clk_Out hold, Tick[i]=0. Re-enabling resumes from the held count; there is no restart.
- Sync=1:
  - every channel gets cnt=0, Tick=0, Clk_Out=0, regardless of En;
  - Sync overrides the terminal-count action in the same cycle;
  - afterwards all channels are phase-aligned.
- Write (Wr_En=1):
  - divisor[Wr_Ch] <= Wr_Div; the counter is not reset;
  - a Wr_Ch value >= NUM_CH is ignored;
  - a write in the same cycle as Sync is accepted;
  - a write in the same cycle as the target channel's terminal count is accepted, and the new N governs the next period.
- Shrinking N below the current cnt makes the next cycle terminal (the >= compare). This gives at most one short period, never a counter wrap through 2^CNT_W.
- Arithmetic: unsigned CNT_W throughout. N-1 is computed only when N != 0, and the counter never overflows.

Optional Feature:
Macro CLKDIV_GLITCHLESS_UPDATE_EN.
- Defined:
  - each channel has a shadow divisor; writes go to the shadow only;
  - the active divisor loads from the shadow on the channel's terminal cycle, on Sync, or while En[i]=0;
  - the period in progress always completes with the old N, so there are no short or runt Clk_Out phases.
- Undefined: writes update the active divisor immediately, with the >= terminal rule above.
- Reset loads both the shadow and the active divisor with RESET_DIV.

Decomposition:
- Package clkdiv_pkg holds:
  - the CNT_W default;
  - the RESET_DIV default;
  - named constants DIV_HALT (0) and DIV_MAX (2^CNT_W-1).
- One natural sub-module, clkdiv_channel, covers a single channel: counter, divisor, optional shadow, Tick and Clk_Out registers.
- The top level instantiates it NUM_CH times with a generate loop and decodes Wr_Ch into per-channel write strobes.

Test Plan:
- Reset=0 for 3 cycles, then 1, with En=2'b11 and defaults → Tick, Clk_Out and cnt all 0 during reset. Then override with Wr_Div=4 on ch0 and 10 on ch1 → Tick[0] every 4 cycles, Tick[1] every 10, Clk_Out periods 8 and 20.
- Wr_Div=1 on ch0 → Tick[0] held high; Clk_Out[0] toggles every cycle. Then Wr_Div=0 → Tick[0]=0 and Clk_Out[0] frozen.
- ch0 at N=10, cnt=7: write N=3 → without macro, Tick the next cycle and then every 3 cycles; with CLKDIV_GLITCHLESS_UPDATE_EN, Tick at cnt 9 and then every 3 cycles.
- N=5: drop En[0] at cnt=2 for 6 cycles, then raise it → no Tick while low; first Tick 3 cycles after re-enable.
- ch0 N=4, ch1 N=6 running: pulse Sync, coinciding with ch0's terminal cycle → ch0 emits no Tick for that cycle, both Clk_Out=0 and both cnt=0. Ticks then realign at cycle 12.
- Assert Reset=0 mid-period with N=6 and a pending write → outputs 0 and divisor = RESET_DIV. Also: a write with Wr_Ch=1 when NUM_CH=1 → no state change.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared defaults and named divisor constants for clock_divider_multi
package clkdiv_pkg;

    // Default counter/divisor width: 26 bits covers 50e6 with headroom.
    localparam int unsigned CNT_W_DEF = 26;

    // Default divisor: 1 Hz square wave from a 100 MHz system clock.
    localparam int unsigned RESET_DIV_DEF = 50000000;

    // A divisor of zero parks the channel.
    localparam int unsigned DIV_HALT = 0;

    // Largest divisor representable at the default width.
    localparam logic [CNT_W_DEF-1:0] DIV_MAX = '1;

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel (counter, divisor, tick, square out); CLKDIV_GLITCHLESS_UPDATE_EN adds a shadow divisor
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RESET_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_m1;
    logic             halted;
    logic             terminal;

    // N-1 is only formed for a non-zero divisor so the compare never sees a wrapped value.
    assign halted   = (div_act == CNT_W'(DIV_HALT));
    assign div_m1   = halted ? '0 : (div_act - CNT_W'(1));
    // Using >= lets a shrunken divisor end the period on the very next cycle instead of wrapping.
    assign terminal = !halted && (cnt >= div_m1);

    // Counter, tick pulse and square-wave state; sync outranks the terminal action.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else if (halted) begin
            cnt     <= '0;
            tick    <= 1'b0;
        end else if (!en) begin
            tick    <= 1'b0;
        end else if (terminal) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
    logic [CNT_W-1:0] div_shadow;
    logic [CNT_W-1:0] shadow_next;
    logic             load;

    // A write in the same cycle as a load point is taken straight through to the active divisor.
    assign shadow_next = wr_en ? wr_div : div_shadow;
    // Halted channels also load, otherwise a channel parked at N=0 with en high could never restart.
    assign load        = sync || !en || halted || terminal;

    // Shadow captures writes; active divisor only changes at a period boundary or while idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_shadow <= DIV_RST;
            div_act    <= DIV_RST;
        end else begin
            div_shadow <= shadow_next;
            if (load) begin
                div_act <= shadow_next;
            end
        end
    end
`else
    // Writes take effect immediately; the counter keeps running.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_act <= DIV_RST;
        end else if (wr_en) begin
            div_act <= wr_div;
        end
    end
`endif

endmodule

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - programmable multi-channel clock divider top; CLKDIV_GLITCHLESS_UPDATE_EN selects deferred divisor updates
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned CH_W      = 1,
    parameter int unsigned RESET_DIV = RESET_DIV_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] En,
    input  logic              Sync,
    input  logic              Wr_En,
    input  logic [CH_W-1:0]   Wr_Ch,
    input  logic [CNT_W-1:0]  Wr_Div,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Clk_Out
);

    logic [NUM_CH-1:0] wr_sel;

    // Decode the channel select; values at or beyond NUM_CH match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Wr_En && (Wr_Ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk     (Clk),
            .resetn  (Reset),
            .en      (En[g]),
            .sync    (Sync),
            .wr_en   (wr_sel[g]),
            .wr_div  (Wr_Div),
            .tick    (Tick[g]),
            .clk_out (Clk_Out[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - scoreboard bench for clock_divider_multi
module tb_clock_divider_multi;

    localparam int RESET_DIV = 50000000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  En;
    logic        Sync;
    logic        Wr_En;
    logic [0:0]  Wr_Ch;
    logic [25:0] Wr_Div;
    logic [1:0]  Tick;
    logic [1:0]  Clk_Out;
    logic        Wr_En1;
    logic [0:0]  Tick1;
    logic [0:0]  Clk_Out1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    ch;
        logic  tk;
        logic  co;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    clock_divider_multi #(
        .NUM_CH    (2),
        .CNT_W     (26),
        .CH_W      (1),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .Sync    (Sync),
        .Wr_En   (Wr_En),
        .Wr_Ch   (Wr_Ch),
        .Wr_Div  (Wr_Div),
        .Tick    (Tick),
        .Clk_Out (Clk_Out)
    );

    clock_divider_multi #(
        .NUM_CH    (1),
        .CNT_W     (8),
        .CH_W      (1),
        .RESET_DIV (3)
    ) dut1 (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En[0:0]),
        .Sync    (1'b0),
        .Wr_En   (Wr_En1),
        .Wr_Ch   (Wr_Ch),
        .Wr_Div  (Wr_Div[7:0]),
        .Tick    (Tick1),
        .Clk_Out (Clk_Out1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_ch(input string tag, input int ch, input logic tk, input logic co);
        exp_t e;
        e.tag = tag;
        e.ch  = ch;
        e.tk  = tk;
        e.co  = co;
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge Clk);
        @(negedge Clk);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.ch == 2) begin
                check({e.tag, "/tick"}, 32'(Tick1[0]), 32'(e.tk));
                check({e.tag, "/co"}, 32'(Clk_Out1[0]), 32'(e.co));
            end else begin
                check({e.tag, "/tick"}, 32'(Tick[e.ch]), 32'(e.tk));
                check({e.tag, "/co"}, 32'(Clk_Out[e.ch]), 32'(e.co));
            end
        end
    endtask

    task automatic idle();
        Sync  = 1'b0;
        Wr_En = 1'b0;
    endtask

    task automatic sync_write(input logic [0:0] ch, input int n, input int mask);
        Sync   = 1'b1;
        Wr_En  = 1'b1;
        Wr_Ch  = ch;
        Wr_Div = 26'(n);
        if (mask[0]) expect_ch("sync_wr", 0, 1'b0, 1'b0);
        if (mask[1]) expect_ch("sync_wr", 1, 1'b0, 1'b0);
        cyc();
    endtask

    // Edge k after an alignment point: tick on multiples of N, square wave flips every N edges.
    task automatic run_periodic(input string tag, input int k_lo, input int k_hi,
                                input int n0, input int n1, input int mask);
        for (int k = k_lo; k <= k_hi; k++) begin
            if (mask[0]) expect_ch(tag, 0, (k % n0) == 0, ((k / n0) % 2) != 0);
            if (mask[1]) expect_ch(tag, 1, (k % n1) == 0, ((k / n1) % 2) != 0);
            cyc();
        end
    endtask

    initial begin
        int first;
        Reset  = 1'b0;
        En     = 2'b11;
        Sync   = 1'b0;
        Wr_En  = 1'b0;
        Wr_Ch  = 1'b0;
        Wr_Div = '0;
        Wr_En1 = 1'b0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            expect_ch("reset", 0, 1'b0, 1'b0);
            expect_ch("reset", 1, 1'b0, 1'b0);
            cyc();
            check("reset_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd0);
            check("reset_div1", 32'(dut.g_ch[1].u_ch.div_act), 32'(RESET_DIV));
        end

        // N=4 on ch0, N=10 on ch1
        Reset = 1'b1;
        sync_write(1'b0, 4, 3);
        sync_write(1'b1, 10, 3);
        idle();
        run_periodic("p4_10", 1, 40, 4, 10, 3);

        // N=1 then N=0 on ch0
        sync_write(1'b0, 1, 3);
        idle();
        run_periodic("n1", 1, 6, 1, 10, 3);
        Wr_En  = 1'b1;
        Wr_Ch  = 1'b0;
        Wr_Div = 26'd0;
        expect_ch("n0_last", 0, 1'b1, 1'b1);
        cyc();
        idle();
        for (int i = 0; i < 5; i++) begin
            expect_ch("n0_halt", 0, 1'b0, 1'b1);
            cyc();
        end

        // shrink N=10 to N=3 at cnt=7
        sync_write(1'b0, 10, 1);
        idle();
        for (int k = 1; k <= 7; k++) begin
            expect_ch("shrink_pre", 0, 1'b0, 1'b0);
            cyc();
        end
        Wr_En  = 1'b1;
        Wr_Ch  = 1'b0;
        Wr_Div = 26'd3;
        expect_ch("shrink_wr", 0, 1'b0, 1'b0);
        cyc();
        idle();
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
        first = 10;
`else
        first = 9;
`endif
        for (int e = 9; e <= 18; e++) begin
            if (e < first) begin
                expect_ch("shrink", 0, 1'b0, 1'b0);
            end else begin
                expect_ch("shrink", 0, ((e - first) % 3) == 0, (((e - first) / 3) % 2) == 0);
            end
            cyc();
        end

        // enable gap at cnt=2 with N=5
        sync_write(1'b0, 5, 1);
        idle();
        for (int k = 1; k <= 2; k++) begin
            expect_ch("gap_pre", 0, 1'b0, 1'b0);
            cyc();
        end
        En = 2'b10;
        for (int k = 0; k < 6; k++) begin
            expect_ch("gap_low", 0, 1'b0, 1'b0);
            cyc();
        end
        En = 2'b11;
        for (int j = 1; j <= 8; j++) begin
            expect_ch("gap_resume", 0, (j >= 3) && (((j - 3) % 5) == 0),
                      (j >= 3) && ((((j - 3) / 5) % 2) == 0));
            cyc();
        end

        // sync landing on ch0's terminal cycle
        sync_write(1'b0, 4, 3);
        sync_write(1'b1, 6, 3);
        idle();
        run_periodic("sync_pre", 1, 3, 4, 6, 3);
        Sync = 1'b1;
        expect_ch("sync_term", 0, 1'b0, 1'b0);
        expect_ch("sync_term", 1, 1'b0, 1'b0);
        cyc();
        check("sync_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd0);
        check("sync_cnt1", 32'(dut.g_ch[1].u_ch.cnt), 32'd0);
        idle();
        run_periodic("realign", 1, 13, 4, 6, 3);

        // reset mid-period with a pending write
        sync_write(1'b0, 6, 1);
        idle();
        run_periodic("pre_rst", 1, 8, 6, 6, 1);
        Reset  = 1'b0;
        Wr_En  = 1'b1;
        Wr_Ch  = 1'b0;
        Wr_Div = 26'd9;
        expect_ch("mid_rst", 0, 1'b0, 1'b0);
        expect_ch("mid_rst", 1, 1'b0, 1'b0);
        cyc();
        check("mid_rst_cnt0", 32'(dut.g_ch[0].u_ch.cnt), 32'd0);
        check("mid_rst_div0", 32'(dut.g_ch[0].u_ch.div_act), 32'(RESET_DIV));
        check("mid_rst_div1", 32'(dut.g_ch[1].u_ch.div_act), 32'(RESET_DIV));

        // out-of-range channel write on a single-channel instance
        Reset  = 1'b1;
        Wr_En  = 1'b0;
        Wr_En1 = 1'b1;
        Wr_Ch  = 1'b1;
        Wr_Div = 26'd1;
        expect_ch("oor_wr", 2, 1'b0, 1'b0);
        cyc();
        Wr_En1 = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            expect_ch("oor_run", 2, (k % 3) == 0, ((k / 3) % 2) != 0);
            cyc();
        end
        check("oor_div", 32'(dut1.g_ch[0].u_ch.div_act), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
